// File: rtl/dedisp_pkg.sv
// Shared definitions for the dedispersor front-end sequencer:
// state encoding and the channel-counter width helper.
package dedisp_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_FILL = ST_FILL,
      S_RUN  = ST_RUN
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dedisp_frame_cnt.sv
// Wrapping channel counter (power-of-two period) with synchronous clear,
// a wrap strobe on the advancing edge and an at-zero flag.
module dedisp_frame_cnt
   import dedisp_pkg::*;
#(
   parameter int unsigned N = 64,
   parameter int unsigned W = cnt_width(N)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_wrap,
   output logic o_zero
);

   logic [W-1:0] r_cnt;
   logic         w_last;

   assign w_last = (r_cnt == W'(N - 1));
   assign o_wrap = i_en && w_last;
   assign o_zero = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/dedisp_stream_ctrl.sv
// Front-end sequencer for the serial dedispersor: locks to the spectrum sync,
// holds the dedispersor in reset until then, and blanks output during fill.
module dedisp_stream_ctrl
   import dedisp_pkg::*;
#(
   parameter int unsigned N_CHANNELS   = 64,
   parameter int unsigned DIN_WIDTH    = 32,
   parameter int unsigned FILL_SPECTRA = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync_in,
   input  logic [DIN_WIDTH-1:0] din,
   input  logic                 din_valid,
   input  logic                 clr_err,
   output logic                 dd_rst,
   output logic [DIN_WIDTH-1:0] dd_din,
   output logic                 dd_din_valid,
   input  logic [DIN_WIDTH-1:0] dd_dout,
   input  logic                 dd_dout_valid,
   output logic [DIN_WIDTH-1:0] dout,
   output logic                 dout_valid,
   output logic                 dout_sof,
   output logic                 dout_eof,
   output logic [1:0]           state,
   output logic                 sync_err
);

   localparam int unsigned SW = cnt_width(FILL_SPECTRA + 1);

   state_t                 r_state;
   logic [SW-1:0]          r_spec_cnt;
   logic                   r_dd_rst;
   logic [DIN_WIDTH-1:0]   r_dd_din;
   logic                   r_dd_din_valid;
   logic                   r_sync_err;
   logic                   r_out_en;
   logic [DIN_WIDTH-1:0]   r_dout;
   logic                   r_dout_valid;
   logic                   r_dout_sof;
   logic                   r_dout_eof;

   logic w_lock, w_err, w_fwd, w_in_clr, w_in_wrap, w_in_zero, w_fill_done;
   logic w_out_wrap, w_out_zero, w_out_set, w_out_qual;

   // Input-side decisions: lock on sync in IDLE, trap sync off channel 0 otherwise.
   assign w_lock      = (r_state == S_IDLE) && din_valid && sync_in;
   assign w_err       = (r_state != S_IDLE) && din_valid && sync_in && !w_in_zero;
   assign w_fwd       = w_lock || ((r_state != S_IDLE) && din_valid && !w_err);
   assign w_in_clr    = (r_state == S_IDLE) ? !w_lock : w_err;
   assign w_fill_done = w_in_wrap && ((32'(r_spec_cnt) + 32'd1) >= FILL_SPECTRA);

   dedisp_frame_cnt #(.N(N_CHANNELS)) u_in_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_in_clr),
      .i_en   (w_fwd),
      .o_wrap (w_in_wrap),
      .o_zero (w_in_zero)
   );

   // Output side: enable only at a frame boundary once in RUN.
   assign w_out_set  = dd_dout_valid && w_out_zero && (r_state == S_RUN);
   assign w_out_qual = dd_dout_valid && (r_out_en || w_out_set);

   dedisp_frame_cnt #(.N(N_CHANNELS)) u_out_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (r_dd_rst),
      .i_en   (dd_dout_valid),
      .o_wrap (w_out_wrap),
      .o_zero (w_out_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_spec_cnt     <= '0;
         r_dd_rst       <= 1'b1;
         r_dd_din       <= '0;
         r_dd_din_valid <= 1'b0;
         r_sync_err     <= 1'b0;
         r_out_en       <= 1'b0;
         r_dout         <= '0;
         r_dout_valid   <= 1'b0;
         r_dout_sof     <= 1'b0;
         r_dout_eof     <= 1'b0;
      end else begin
         r_dd_din_valid <= w_fwd;
         if (w_fwd) r_dd_din <= din;

         if (w_err)        r_sync_err <= 1'b1;
         else if (clr_err) r_sync_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_dd_rst <= 1'b1;
               if (w_lock) begin
                  r_state    <= S_FILL;
                  r_dd_rst   <= 1'b0;
                  r_spec_cnt <= '0;
               end
            end
            S_FILL: begin
               if (w_err) begin
                  r_state  <= S_IDLE;
                  r_dd_rst <= 1'b1;
               end else if (w_in_wrap) begin
                  if (w_fill_done) r_state <= S_RUN;
                  if (r_spec_cnt != SW'(FILL_SPECTRA)) r_spec_cnt <= r_spec_cnt + SW'(1);
               end
            end
            S_RUN: begin
               if (w_err) begin
                  r_state  <= S_IDLE;
                  r_dd_rst <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_dd_rst <= 1'b1;
            end
         endcase

         // Leaving RUN (only via error) drops the enable on the same edge.
         r_out_en     <= (r_state == S_RUN) && !w_err && (r_out_en || w_out_set);
         r_dout_valid <= w_out_qual;
         r_dout_sof   <= w_out_qual && w_out_zero;
         r_dout_eof   <= w_out_qual && w_out_wrap;
         if (w_out_qual) r_dout <= dd_dout;
      end
   end

   assign state        = r_state;
   assign dd_rst       = r_dd_rst;
   assign dd_din       = r_dd_din;
   assign dd_din_valid = r_dd_din_valid;
   assign sync_err     = r_sync_err;
   assign dout         = r_dout;
   assign dout_valid   = r_dout_valid;
   assign dout_sof     = r_dout_sof;
   assign dout_eof     = r_dout_eof;

endmodule

// File: doc/dedisp_stream_ctrl.md
# dedisp_stream_ctrl

Front-end sequencer for the serial dedispersor. Sits between the FFT/power stage and the dedispersor. It aligns the serial channel stream to the spectrum sync pulse, holds the dedispersor in reset until alignment, and blanks its output while the delay lines fill. It also rebuilds start/end-of-frame flags on the output side and traps sync misalignment.

## Interface
Parameters:
- N_CHANNELS, 64, channels per spectrum (power of 2); must match the dedispersor.
- DIN_WIDTH, 32, sample width.
- FILL_SPECTRA, 9, whole spectra to forward before output is enabled (≥ largest channel delay).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sync_in  in  1  marks channel 0 of a spectrum; qualified by din_valid.
- din  in  DIN_WIDTH  input sample.
- din_valid  in  1  input qualifier.
- clr_err  in  1  clears sync_err.
- dd_rst  out  1  reset to the dedispersor.
- dd_din  out  DIN_WIDTH  sample to the dedispersor.
- dd_din_valid  out  1  qualifier to the dedispersor.
- dd_dout  in  DIN_WIDTH  dedispersor output sample.
- dd_dout_valid  in  1  dedispersor output qualifier.
- dout  out  DIN_WIDTH  gated output sample.
- dout_valid  out  1  gated output qualifier.
- dout_sof  out  1  with dout_valid on output channel 0.
- dout_eof  out  1  with dout_valid on output channel N_CHANNELS-1.
- state  out  2  IDLE=0, FILL=1, RUN=2.
- sync_err  out  1  sticky misalignment flag.

## Operation
- Accept = din_valid high. sync_in without din_valid is ignored.
- In_cnt: log2(N_CHANNELS)-bit channel counter. Advances only on accept and wraps from N-1 to 0. spec_cnt counts wraps and saturates at FILL_SPECTRA.
- IDLE:
  - dd_rst=1 and all input is dropped.
  - An accept with sync_in moves to FILL. That sample is forwarded as channel 0, in_cnt←1, spec_cnt←0.
- FILL:
  - Forward every accept.
  - When in_cnt wraps and spec_cnt reaches FILL_SPECTRA, move to RUN.
- RUN: forward every accept.
- Misalignment:
  - In FILL or RUN, an accept with sync_in and in_cnt≠0 sets sync_err and moves to IDLE.
  - That sample is dropped and dd_rst is reasserted.
  - A missing sync at in_cnt=0 is tolerated (free-run).
- Clearing sync_err: clr_err clears it. If an error occurs in the same cycle as clr_err, the error wins.
- Output side:
  - out_cnt advances on dd_dout_valid and is held at 0 while dd_rst=1.
  - out_en is set on the first dd_dout_valid with out_cnt=0 while state=RUN. It is cleared whenever state≠RUN.
  - Output qualification: dout_valid = dd_dout_valid ∧ out_en (including the setting cycle).
  - dout_sof and dout_eof are qualified by dout_valid.

## Timing
- Reset values (one edge after rst):
  - state=IDLE, dd_rst=1.
  - dd_din=0, dd_din_valid=0, dout=0, dout_valid=0, dout_sof=0, dout_eof=0, sync_err=0.
  - All counters 0, out_en=0.
- Input path: dd_din, dd_din_valid and dd_rst are registered together, 1-cycle latency. dd_rst falls on the same edge that presents channel 0.
- Output path: dd_dout → dout is registered, 1-cycle latency. dout_valid, dout_sof and dout_eof are aligned with dout.
- dout holds its last value when dout_valid=0.
- A state transition takes effect on the edge after the deciding accept. An error in RUN drops out_en on that same edge, so there are no partial frames after the error is detected.
- A reset mid-operation behaves identically to a power-on reset. The next sync restarts from IDLE.
- Gaps in din_valid are arbitrary. Framing depends only on the accept count.

## Structure
- Package dedisp_pkg: state encoding localparams (ST_IDLE, ST_FILL, ST_RUN) and a clog2 helper constant for the channel width.
- Sub-module dedisp_frame_cnt: an enable-driven, wrapping channel counter with wrap and at-zero outputs. It is instantiated twice, for in_cnt and out_cnt.
- The FSM and gating logic live in the top level.

## Test plan
All scenarios use N_CHANNELS=8 and FILL_SPECTRA=3.
- Reset: hold rst for 2 cycles → dd_rst=1, state=0, all other outputs 0.
- No sync: send 20 accepts without sync_in → dd_din_valid stays 0, state=0, dd_rst=1.
- Lock:
  - Sync on sample 0, then continuous valid → next cycle dd_rst=0, dd_din_valid=1, state=1.
  - After 24 accepts, state=2.
  - The first dout_valid coincides with dout_sof=1; dout_eof=1 follows exactly 7 valids later.
- Misalignment: sync_in on channel 5 while in RUN → next cycle sync_err=1, state=0, dd_rst=1, dd_din_valid=0. A later sync on channel 0 resumes FILL. clr_err clears sync_err.
- Gapped input: din_valid pattern 1,0,1,0… → in_cnt advances on valid cycles only; the RUN transition occurs after 24 accepts (48 cycles).
- Mid-RUN reset: assert rst during dout_valid → dout_valid=0 and state=0 the next cycle. No dout_sof until relock plus 3 spectra.
